fibo_checker: RTL and testbench

Receive-side checker for a Fibonacci-number stream. Accepts one sample per `in_valid` beat and verifies that each sample equals the sum, modulo 2^WIDTH, of the two preceding accepted samples. It reports per-sample match/error pulses, a lock indication after a run of consecutive matches, and a saturating error count. It sits downstream of the team's Fibonacci series generator, or any source claiming to emit the sequence, as a self-check and monitor block.

---
 rtl/fibo_checker.sv | 141 ++++++++++++++
 tb/tb_fibo_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fibo_checker.sv
// rtl/fibo_checker.sv - receive-side checker for a Fibonacci-number sample stream
//
// Each accepted sample is compared against the sum (mod 2^WIDTH) of the two
// previously accepted samples.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous clear, same effect as reset, beats in_valid
//   in_valid   in   sample qualifier
//   in_data    in   [WIDTH-1:0] sample value
//   match      out  one-cycle pulse, accepted sample matched the prediction
//   error      out  one-cycle pulse, accepted sample mismatched
//   locked     out  level, LOCK_COUNT consecutive matches since last error/seed/clear
//   expected   out  [WIDTH-1:0] prediction for the next sample (0 until two samples held)
//   err_count  out  [CNT_WIDTH-1:0] saturating mismatch count
module fibo_checker #(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 match,
    output logic                 error,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_CHECK,
        S_LOCK
    } state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     h0, h1, h0_n, h1_n;
    logic [RUN_W-1:0]     run, run_n, run_inc;
    logic                 match_n, error_n;
    logic [WIDTH-1:0]     expected_n;
    logic [CNT_WIDTH-1:0] err_count_n;
    logic [WIDTH-1:0]     sum_cur;
    logic [WIDTH-1:0]     sum_next;

    // Carry out of the WIDTH-bit adds is dropped so wrapped sequences still match.
    assign sum_cur  = h1 + h0;
    assign sum_next = h0 + in_data;
    assign run_inc  = run + 1'b1;

    always_comb begin
        state_n     = state;
        h0_n        = h0;
        h1_n        = h1;
        run_n       = run;
        match_n     = 1'b0;
        error_n     = 1'b0;
        expected_n  = expected;
        err_count_n = err_count;

        if (clear) begin
            state_n     = S_EMPTY;
            h0_n        = '0;
            h1_n        = '0;
            run_n       = '0;
            expected_n  = '0;
            err_count_n = '0;
        end else if (in_valid) begin
            case (state)
                S_EMPTY: begin
                    h0_n    = in_data;
                    state_n = S_ONE;
                end
                S_ONE: begin
                    h1_n       = h0;
                    h0_n       = in_data;
                    run_n      = '0;
                    expected_n = sum_next;
                    state_n    = S_CHECK;
                end
                S_CHECK, S_LOCK: begin
                    // History always advances; on mismatch this re-seeds
                    // from the last two samples actually received.
                    h1_n       = h0;
                    h0_n       = in_data;
                    expected_n = sum_next;
                    if (in_data == sum_cur) begin
                        match_n = 1'b1;
                        // run is already saturated at LOCK_COUNT while locked
                        if (state == S_CHECK) begin
                            run_n = run_inc;
                            if (run_inc == LOCK_RUN) begin
                                state_n = S_LOCK;
                            end
                        end
                    end else begin
                        error_n = 1'b1;
                        run_n   = '0;
                        state_n = S_CHECK;
                        if (!(&err_count)) begin
                            err_count_n = err_count + 1'b1;
                        end
                    end
                end
                default: state_n = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            h0        <= '0;
            h1        <= '0;
            run       <= '0;
            match     <= 1'b0;
            error     <= 1'b0;
            expected  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            h0        <= h0_n;
            h1        <= h1_n;
            run       <= run_n;
            match     <= match_n;
            error     <= error_n;
            expected  <= expected_n;
            err_count <= err_count_n;
        end
    end

    assign locked = (state == S_LOCK);

endmodule

// File: tb/tb_fibo_checker.sv
// tb/tb_fibo_checker.sv - table-driven self-checking bench for fibo_checker
module tb_fibo_checker;

    logic       clk;
    logic       rst;
    logic       clr1, vld1;
    logic [4:0] dat1;
    logic       m1, e1, l1;
    logic [4:0] x1;
    logic [7:0] c1;

    logic       clr2, vld2;
    logic [4:0] dat2;
    logic       m2, e2, l2;
    logic [4:0] x2;
    logic [1:0] c2;

    int checks = 0;
    int passes = 0;

    fibo_checker #(.WIDTH(5), .LOCK_COUNT(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clr1), .in_valid(vld1), .in_data(dat1),
        .match(m1), .error(e1), .locked(l1), .expected(x1), .err_count(c1)
    );

    fibo_checker #(.WIDTH(5), .LOCK_COUNT(3), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .clear(clr2), .in_valid(vld2), .in_data(dat2),
        .match(m2), .error(e2), .locked(l2), .expected(x2), .err_count(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       vld;
        logic [4:0] data;
        logic       m;
        logic       e;
        logic       l;
        logic [4:0] x;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic clr, input logic vld, input int data,
                                input logic m, input logic e, input logic l,
                                input int x, input int c);
        vec_t v;
        v.clr = clr; v.vld = vld; v.data = 5'(data);
        v.m = m; v.e = e; v.l = l; v.x = 5'(x); v.c = 8'(c);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    endtask

    task automatic apply1(input logic c, input logic v, input logic [4:0] d);
        @(negedge clk);
        clr1 = c; vld1 = v; dat1 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic v, input logic [4:0] d);
        @(negedge clk);
        vld2 = v; dat2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all1(input string tag, input logic m, input logic e,
                            input logic l, input int x, input int c);
        chk({tag, " match"}, m1, m);
        chk({tag, " error"}, e1, e);
        chk({tag, " locked"}, l1, l);
        chk({tag, " expected"}, x1, x);
        chk({tag, " err_count"}, c1, c);
    endtask

    initial begin
        rst = 1'b1;
        clr1 = 1'b0; vld1 = 1'b0; dat1 = '0;
        clr2 = 1'b0; vld2 = 1'b0; dat2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all1("reset", 1'b0, 1'b0, 1'b0, 0, 0);

        // lock acquisition
        add(0,1,0, 0,0,0, 0,0);
        add(0,1,1, 0,0,0, 1,0);
        add(0,1,1, 1,0,0, 2,0);
        add(0,1,2, 1,0,0, 3,0);
        add(0,1,3, 1,0,1, 5,0);
        add(0,1,5, 1,0,1, 8,0);
        add(0,1,8, 1,0,1, 13,0);
        add(0,0,31, 0,0,1, 13,0);
        // clear with a valid sample: sample discarded
        add(1,1,13, 0,0,0, 0,0);
        // error and resync
        add(0,1,0, 0,0,0, 0,0);
        add(0,1,1, 0,0,0, 1,0);
        add(0,1,1, 1,0,0, 2,0);
        add(0,1,2, 1,0,0, 3,0);
        add(0,1,3, 1,0,1, 5,0);
        add(0,1,5, 1,0,1, 8,0);
        add(0,1,9, 0,1,0, 14,1);
        add(0,1,14, 1,0,0, 23,1);
        add(0,1,23, 1,0,0, 5,1);
        add(0,1,5, 1,0,1, 28,1);
        // wrap-around
        add(1,0,0, 0,0,0, 0,0);
        add(0,1,13, 0,0,0, 0,0);
        add(0,1,21, 0,0,0, 2,0);
        add(0,1,2, 1,0,0, 23,0);
        add(0,1,23, 1,0,0, 25,0);
        add(0,1,25, 1,0,1, 16,0);
        add(0,1,16, 1,0,1, 9,0);
        // clear while locked with a sample present
        add(1,1,25, 0,0,0, 0,0);
        // idle gaps between samples
        add(0,1,0, 0,0,0, 0,0);
        add(0,0,7, 0,0,0, 0,0);
        add(0,1,1, 0,0,0, 1,0);
        add(0,0,2, 0,0,0, 1,0);
        add(0,0,2, 0,0,0, 1,0);
        add(0,1,1, 1,0,0, 2,0);
        add(0,0,9, 0,0,0, 2,0);
        add(0,1,2, 1,0,0, 3,0);
        add(0,0,0, 0,0,0, 3,0);
        add(0,0,0, 0,0,0, 3,0);
        add(0,0,0, 0,0,0, 3,0);
        add(0,1,3, 1,0,1, 5,0);
        add(0,0,4, 0,0,1, 5,0);
        add(0,1,5, 1,0,1, 8,0);
        add(0,0,1, 0,0,1, 8,0);
        add(0,0,1, 0,0,1, 8,0);
        add(0,1,8, 1,0,1, 13,0);
        add(0,0,0, 0,0,1, 13,0);

        foreach (vecs[i]) begin
            apply1(vecs[i].clr, vecs[i].vld, vecs[i].data);
            chk($sformatf("vec%0d match", i), m1, vecs[i].m);
            chk($sformatf("vec%0d error", i), e1, vecs[i].e);
            chk($sformatf("vec%0d locked", i), l1, vecs[i].l);
            chk($sformatf("vec%0d expected", i), x1, vecs[i].x);
            chk($sformatf("vec%0d err_count", i), c1, vecs[i].c);
        end

        // asynchronous reset mid-stream, with an error already counted
        apply1(1'b1, 1'b0, 5'd0);
        apply1(1'b0, 1'b1, 5'd0);
        apply1(1'b0, 1'b1, 5'd1);
        apply1(1'b0, 1'b1, 5'd5);
        apply1(1'b0, 1'b1, 5'd6);
        apply1(1'b0, 1'b1, 5'd11);
        apply1(1'b0, 1'b1, 5'd17);
        chk_all1("pre-rst", 1'b1, 1'b0, 1'b1, 28, 1);
        @(negedge clk);
        vld1 = 1'b1; dat1 = 5'($urandom_range(0, 31));
        #2;
        rst = 1'b1;
        #1;
        chk_all1("async rst", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vld1 = 1'($urandom_range(0, 1));
            dat1 = 5'($urandom_range(0, 31));
            clr1 = 1'($urandom_range(0, 1));
        end
        #1;
        chk_all1("held rst", 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b0; clr1 = 1'b0; vld1 = 1'b0;
        apply1(1'b0, 1'b1, 5'd3);
        chk_all1("seed1", 1'b0, 1'b0, 1'b0, 0, 0);
        apply1(1'b0, 1'b1, 5'd4);
        chk_all1("seed2", 1'b0, 1'b0, 1'b0, 7, 0);
        apply1(1'b0, 1'b1, 5'd7);
        chk_all1("post-seed", 1'b1, 1'b0, 1'b0, 11, 0);
        apply1(1'b0, 1'b0, 5'd0);

        // saturation with a 2-bit error counter
        apply2(1'b1, 5'd0);
        apply2(1'b1, 5'd1);
        chk("sat seed error", e2, 0);
        begin
            logic [4:0] bad [5];
            bad[0] = 5'd0; bad[1] = 5'd0; bad[2] = 5'd1; bad[3] = 5'd0; bad[4] = 5'd0;
            for (int n = 0; n < 5; n++) begin
                apply2(1'b1, bad[n]);
                chk($sformatf("sat%0d error", n), e2, 1);
                chk($sformatf("sat%0d match", n), m2, 0);
                chk($sformatf("sat%0d err_count", n), c2, (n + 1 > 3) ? 3 : n + 1);
            end
        end
        apply2(1'b0, 5'd0);
        chk("sat idle error", e2, 0);
        chk("sat idle count", c2, 3);
        chk("sat locked", l2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
